// File: rtl/egd_pkg.sv
// Shared types and arithmetic for the order-k Exp-Golomb decoder.
// Optional macro EGD_SIGNED_MAP_EN adds the se(v) signed mapping function.
package egd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        SUFFIX,
        HOLD,
        DROP
    } egd_state_e;

    // codeNum = 2^(n+k) - 2^k + info; callers truncate to their output width.
    function automatic logic [31:0] egd_codenum(input logic [31:0] n,
                                                input logic [31:0] k,
                                                input logic [31:0] info);
        return (32'd1 << (n + k)) - (32'd1 << k) + info;
    endfunction

`ifdef EGD_SIGNED_MAP_EN
    function automatic logic [31:0] egd_se_map(input logic [31:0] c);
        if (c[0]) begin
            return (c + 32'd1) >> 1;
        end
        return 32'd0 - (c >> 1);
    endfunction
`endif

endpackage

// File: rtl/egd_out_stage.sv
// Output holding register with po_valid/po_ready handshake.
// With EGD_SIGNED_MAP_EN the loaded codeNum can be passed through the se(v) map.
module egd_out_stage
    import egd_pkg::*;
#(
    parameter int OUT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_err,
    input  logic [OUT_W-1:0] load_code,
`ifdef EGD_SIGNED_MAP_EN
    input  logic             load_map,
`endif
    input  logic             po_ready,
    output logic             po_valid,
    output logic [OUT_W-1:0] po_data,
    output logic             po_err
);

    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             err_q, err_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (load) begin
            valid_d = 1'b1;
            err_d   = load_err;
            if (load_err) begin
                data_d = '0;
            end
`ifdef EGD_SIGNED_MAP_EN
            else if (load_map) begin
                data_d = OUT_W'(egd_se_map(32'(load_code)));
            end
`endif
            else begin
                data_d = load_code;
            end
        end else if (valid_q && po_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign po_valid = valid_q;
    assign po_data  = data_q;
    assign po_err   = err_q;

endmodule

// File: rtl/egd_k_decoder.sv
// Serial order-k Exp-Golomb decoder, one code bit per accepted cycle.
// Optional macro EGD_SIGNED_MAP_EN adds the map_se input for se(v) output.
module egd_k_decoder
    import egd_pkg::*;
#(
    parameter int MAX_PREFIX = 7,
    parameter int K_MAX      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           si_valid,
    input  logic                           si_data,
    output logic                           si_ready,
    input  logic [$clog2(K_MAX+1)-1:0]     k,
`ifdef EGD_SIGNED_MAP_EN
    input  logic                           map_se,
`endif
    output logic                           po_valid,
    input  logic                           po_ready,
    output logic [MAX_PREFIX+K_MAX:0]      po_data,
    output logic                           po_err
);

    localparam int OUT_W = MAX_PREFIX + K_MAX + 1;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int NW    = $clog2(MAX_PREFIX + 1);
    localparam int IW    = MAX_PREFIX + K_MAX;
    localparam int RW    = $clog2(IW + 1);

    egd_state_e       state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [KW-1:0]    k_q, k_d;
    logic             map_q, map_d;
    // The final info bit arrives combinationally, so only IW-1 bits are stored.
    logic [IW-2:0]    info_q, info_d;
    logic [IW-1:0]    info_full;
    logic [KW-1:0]    k_clamp;
    logic             accept;
    logic             load, load_err;
    logic [OUT_W-1:0] load_code;

    assign si_ready  = rst && (state_q != HOLD);
    assign accept    = si_valid && si_ready;
    assign k_clamp   = (32'(k) > K_MAX) ? KW'(K_MAX) : k;
    assign info_full = {info_q, si_data};

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rem_d     = rem_q;
        k_d       = k_q;
        map_d     = map_q;
        info_d    = info_q;
        load      = 1'b0;
        load_err  = 1'b0;
        load_code = '0;
        case (state_q)
            IDLE: if (accept) begin
`ifdef EGD_SIGNED_MAP_EN
                map_d = map_se;
`else
                map_d = 1'b0;
`endif
                k_d    = k_clamp;
                info_d = '0;
                if (si_data) begin
                    n_d     = NW'(1);
                    state_d = PREFIX;
                end else begin
                    n_d = '0;
                    if (k_clamp == '0) begin
                        load    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        rem_d   = RW'(k_clamp);
                        state_d = SUFFIX;
                    end
                end
            end
            PREFIX: if (accept) begin
                if (!si_data) begin
                    rem_d   = RW'(n_q) + RW'(k_q);
                    state_d = SUFFIX;
                end else if (n_q == NW'(MAX_PREFIX)) begin
                    state_d = DROP;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            SUFFIX: if (accept) begin
                info_d = info_full[IW-2:0];
                rem_d  = rem_q - RW'(1);
                if (rem_q == RW'(1)) begin
                    load      = 1'b1;
                    load_code = OUT_W'(egd_codenum(32'(n_q), 32'(k_q), 32'(info_full)));
                    state_d   = HOLD;
                end
            end
            DROP: if (accept && !si_data) begin
                load     = 1'b1;
                load_err = 1'b1;
                state_d  = HOLD;
            end
            HOLD: if (po_ready) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            rem_q   <= '0;
            k_q     <= '0;
            map_q   <= 1'b0;
            info_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            map_q   <= map_d;
            info_q  <= info_d;
        end
    end

    // map_d covers both the IDLE->HOLD path (fresh sample) and SUFFIX->HOLD (latched).
    egd_out_stage #(.OUT_W(OUT_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_err  (load_err),
        .load_code (load_code),
`ifdef EGD_SIGNED_MAP_EN
        .load_map  (map_d),
`endif
        .po_ready  (po_ready),
        .po_valid  (po_valid),
        .po_data   (po_data),
        .po_err    (po_err)
    );

endmodule

// File: tb/tb_egd_k_decoder.sv
// Scoreboard bench for egd_k_decoder: directed codes plus randomized codes.
// Define EGD_SIGNED_MAP_EN to also exercise the signed mapping.
module tb_egd_k_decoder;

    localparam int MAX_PREFIX = 7;
    localparam int K_MAX      = 3;
    localparam int OUT_W      = MAX_PREFIX + K_MAX + 1;
    localparam int KW         = $clog2(K_MAX + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             si_valid = 1'b0;
    logic             si_data = 1'b0;
    logic             si_ready;
    logic [KW-1:0]    k = '0;
    logic             po_valid;
    logic             po_ready = 1'b1;
    logic [OUT_W-1:0] po_data;
    logic             po_err;
`ifdef EGD_SIGNED_MAP_EN
    logic             map_se = 1'b0;
`endif

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;

    egd_k_decoder #(.MAX_PREFIX(MAX_PREFIX), .K_MAX(K_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .si_valid (si_valid),
        .si_data  (si_data),
        .si_ready (si_ready),
        .k        (k),
`ifdef EGD_SIGNED_MAP_EN
        .map_se   (map_se),
`endif
        .po_valid (po_valid),
        .po_ready (po_ready),
        .po_data  (po_data),
        .po_err   (po_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_val(input int n, input int kk, input int info, input bit mp);
        longint c;
        c = (longint'(1) << (n + kk)) - (longint'(1) << kk) + longint'(info);
        if (mp) c = (c % 2 == 1) ? (c + 1) / 2 : -(c / 2);
        return OUT_W'(c);
    endfunction

    task automatic push(input logic [OUT_W-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // po_ready: 0 = always 1, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #2;
            po_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
        end
    end

    always @(negedge clk) begin
        if (rst && po_valid) begin
            check("si_ready_in_hold", 32'(si_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                check("po_data", 32'(po_data), 32'(exp_q[0].data));
                check("po_err", 32'(po_err), 32'(exp_q[0].err));
                if (po_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clk);
            if (si_ready) done = 1;
            else begin
                t++;
                if (t > 200) begin
                    check("accept_timeout", 32'd1, 32'd0);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // gm: 0 = no gaps, 1 = random gaps, 2 = one idle cycle before every non-first bit
    task automatic send_code(input bit b[$], input int kv, input bit mp, input int gm);
        for (int i = 0; i < b.size(); i++) begin
            if ((gm == 1 && $urandom_range(0, 3) == 0) || (gm == 2 && i > 0)) begin
                si_valid = 1'b0;
                si_data  = 1'($urandom);
                repeat ((gm == 2) ? 1 : $urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            si_valid = 1'b1;
            si_data  = b[i];
            k        = (i == 0) ? KW'(kv) : KW'($urandom);
`ifdef EGD_SIGNED_MAP_EN
            map_se   = (i == 0) ? mp : 1'($urandom);
`else
            if (mp) check("map_unsupported", 32'd1, 32'd0);
`endif
            wait_accept();
        end
        si_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int kv, input bit mp, input int gm);
        bit b[$];
        for (int i = 0; i < s.len(); i++) b.push_back(s[i] == 8'h31);
        send_code(b, kv, mp, gm);
    endtask

    task automatic gen_and_send();
        bit b[$];
        int kv, n, info;
        bit mp;
        kv = $urandom_range(0, K_MAX);
`ifdef EGD_SIGNED_MAP_EN
        mp = 1'($urandom);
`else
        mp = 1'b0;
`endif
        if ($urandom_range(0, 7) == 0) begin
            n = MAX_PREFIX + 1 + $urandom_range(0, 3);
            for (int i = 0; i < n; i++) b.push_back(1'b1);
            b.push_back(1'b0);
            push('0, 1'b1);
        end else begin
            n    = $urandom_range(0, MAX_PREFIX);
            info = $urandom_range(0, (1 << (n + kv)) - 1);
            for (int i = 0; i < n; i++) b.push_back(1'b1);
            b.push_back(1'b0);
            for (int i = n + kv - 1; i >= 0; i--) b.push_back(1'((info >> i) & 1));
            push(ref_val(n, kv, info, mp), 1'b0);
        end
        send_code(b, kv, mp, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            check("rst_po_valid", 32'(po_valid), 32'd0);
            check("rst_po_data", 32'(po_data), 32'd0);
            check("rst_po_err", 32'(po_err), 32'd0);
            check("rst_si_ready", 32'(si_ready), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_si_ready", 32'(si_ready), 32'd1);
        @(posedge clk);
        #1;

        // k=0 basics
        push(11'd0, 1'b0);  send_str("0", 0, 0, 0);
        push(11'd2, 1'b0);  send_str("101", 0, 0, 0);
        push(11'd12, 1'b0); send_str("1110101", 0, 0, 0);
        // nonzero k; later-bit k values are randomized by the driver
        push(11'd3, 1'b0);  send_str("011", 2, 0, 0);
        push(11'd3, 1'b0);  send_str("1001", 1, 0, 0);
        // prefix overflow then normal recovery
        push(11'd0, 1'b1);  send_str("11111111110", 0, 0, 0);
        push(11'd1, 1'b0);  send_str("100", 0, 0, 0);
        drain();

        // backpressure: hold output for several cycles while next bit is offered
        rdy_mode = 2;
        push(11'd2, 1'b0);  send_str("101", 0, 0, 0);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 rdy_mode = 0;
            end
        join_none
        push(11'd4, 1'b0);  send_str("11001", 0, 0, 0);
        drain();

        // alternating gaps
        push(11'd6, 1'b0);  send_str("11011", 0, 0, 2);
        drain();

        // reset mid-code discards the partial prefix
        send_str("11", 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_si_ready", 32'(si_ready), 32'd0);
        check("midrst_po_valid", 32'(po_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        push(11'd0, 1'b0);  send_str("0", 0, 0, 0);
        drain();

`ifdef EGD_SIGNED_MAP_EN
        push(11'd0, 1'b0);     send_str("0", 0, 1, 0);
        push(11'd1, 1'b0);     send_str("100", 0, 1, 0);
        push(11'h7FF, 1'b0);   send_str("101", 0, 1, 0);
        drain();
`endif

        rdy_mode = 1;
        repeat (300) gen_and_send();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
